// File: rtl/mux8way_rr_collector_pkg.sv
// Shared types and the rotate-priority helper for the 8-way round-robin collector.
// Packet locking (MUX8WAY_PKT_LOCK_EN) uses lock_state_t from here.
package mux8way_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int NCH           = 8;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  chsel_t;

    typedef struct packed {
        logic   found;
        chsel_t sel;
    } pick_t;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } lock_state_t;

    // Scans from the highest offset down so the channel closest to ptr wins last.
    function automatic pick_t rr_pick(input logic [NCH-1:0] valid, input chsel_t ptr);
        pick_t  r;
        chsel_t idx;
        r.found = 1'b0;
        r.sel   = ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = ptr + chsel_t'(k);
            if (valid[idx]) begin
                r.found = 1'b1;
                r.sel   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux8way_rr_collector_if.sv
// Bundle of the eight input channels and the merged output stream.
// in_last/out_last exist only when MUX8WAY_PKT_LOCK_EN is defined.
interface mux8way_rr_collector_if import mux8way_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    chsel_t               out_sel;
    logic                 out_ready;
`ifdef MUX8WAY_PKT_LOCK_EN
    logic [NCH-1:0]       in_last;
    logic                 out_last;
`endif

    modport master (
        output in_valid, in_data, out_ready,
`ifdef MUX8WAY_PKT_LOCK_EN
        output in_last,
        input  out_last,
`endif
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef MUX8WAY_PKT_LOCK_EN
        input  in_last,
        output out_last,
`endif
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/mux8way_rr_collector_rr_arbiter8.sv
// Round-robin arbiter for eight requesters with its rotating pointer register.
// With MUX8WAY_PKT_LOCK_EN the grant sticks to one channel until its last word.
module rr_arbiter8 import mux8way_pkg::*; (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] valid,
`ifdef MUX8WAY_PKT_LOCK_EN
    input  logic [NCH-1:0] last,
`endif
    input  logic           load,
    output logic [NCH-1:0] grant,
    output chsel_t         grant_sel
);

    chsel_t rr_ptr, rr_ptr_nxt;
    pick_t  pick;
`ifdef MUX8WAY_PKT_LOCK_EN
    lock_state_t state, state_nxt;
    chsel_t      lock_ch, lock_ch_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
`ifdef MUX8WAY_PKT_LOCK_EN
            state   <= ARB_OPEN;
            lock_ch <= '0;
`endif
        end else begin
            rr_ptr  <= rr_ptr_nxt;
`ifdef MUX8WAY_PKT_LOCK_EN
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
`endif
        end
    end

    // The pointer only moves past a channel once its packet has finished.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
`ifdef MUX8WAY_PKT_LOCK_EN
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
`endif
        if (|grant) begin
`ifdef MUX8WAY_PKT_LOCK_EN
            if (last[grant_sel]) begin
                rr_ptr_nxt = grant_sel + 3'd1;
                state_nxt  = ARB_OPEN;
            end else begin
                state_nxt   = ARB_LOCKED;
                lock_ch_nxt = grant_sel;
            end
`else
            rr_ptr_nxt = grant_sel + 3'd1;
`endif
        end
    end

    always_comb begin
        pick = rr_pick(valid, rr_ptr);
`ifdef MUX8WAY_PKT_LOCK_EN
        if (state == ARB_LOCKED) begin
            pick.found = valid[lock_ch];
            pick.sel   = lock_ch;
        end
`endif
        grant_sel = pick.sel;
        grant     = '0;
        if (pick.found && load) begin
            grant[pick.sel] = 1'b1;
        end
    end

endmodule

// File: rtl/mux8way_rr_collector.sv
// 8-to-1 round-robin stream merger with one registered output stage tagged by source.
// Define MUX8WAY_PKT_LOCK_EN to keep multi-word packets contiguous (in_last/out_last).
module mux8way_rr_collector import mux8way_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input logic                   clk,
    input logic                   reset,
    mux8way_rr_collector_if.slave bus
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    chsel_t           out_sel_q;
    logic             load;
    logic [NCH-1:0]   grant;
    chsel_t           grant_sel;
`ifdef MUX8WAY_PKT_LOCK_EN
    logic             out_last_q;
`endif

    // Refill is allowed in the same cycle the held word drains.
    assign load = !out_valid_q || bus.out_ready;

    rr_arbiter8 u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (bus.in_valid),
`ifdef MUX8WAY_PKT_LOCK_EN
        .last      (bus.in_last),
`endif
        .load      (load),
        .grant     (grant),
        .grant_sel (grant_sel)
    );

    assign bus.in_ready  = reset ? '0 : grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
`ifdef MUX8WAY_PKT_LOCK_EN
    assign bus.out_last  = out_last_q;
`endif

    // Data and tag hold their last values after a drain; only valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifdef MUX8WAY_PKT_LOCK_EN
            out_last_q  <= 1'b0;
`endif
        end else if (load) begin
            if (|grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data[grant_sel*WIDTH +: WIDTH];
                out_sel_q   <= grant_sel;
`ifdef MUX8WAY_PKT_LOCK_EN
                out_last_q  <= bus.in_last[grant_sel];
`endif
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux8way_rr_collector.sv
// Scoreboard bench for mux8way_rr_collector: directed vectors push expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_mux8way_rr_collector;
    import mux8way_pkg::*;

    typedef struct {
        word_t  data;
        chsel_t sel;
        logic   last;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    mux8way_rr_collector_if #(.WIDTH(16)) bus();

    mux8way_rr_collector #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int ch, input word_t w);
        bus.in_data[ch*16 +: 16] = w;
    endtask

    task automatic push(input word_t d, input chsel_t s, input logic l);
        exp_t e;
        e.data = d;
        e.sel  = s;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [7:0] valid, input logic ready);
        bus.in_valid  = valid;
        bus.out_ready = ready;
    endtask

    // Monitor: a word leaves the DUT whenever valid and ready meet at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_word", {13'd0, bus.out_sel, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_output("out_data", 32'(bus.out_data), 32'(e.data));
                check_output("out_sel", 32'(bus.out_sel), 32'(e.sel));
`ifdef MUX8WAY_PKT_LOCK_EN
                check_output("out_last", 32'(bus.out_last), 32'(e.last));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_data = '0;
`ifdef MUX8WAY_PKT_LOCK_EN
        bus.in_last = '0;
`endif
        apply_stimulus(8'hFF, 1'b1);

        // Reset holds everything at zero even with all channels requesting.
        @(negedge clk);
        check_output("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check_output("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_output("rst_out_data", 32'(bus.out_data), 32'h0);
        check_output("rst_out_sel", 32'(bus.out_sel), 32'h0);
        @(posedge clk);
        #1;
        apply_stimulus(8'h00, 1'b1);
        reset = 1'b0;
        tick();

        // Round robin over all eight channels, no bubbles.
        for (int i = 0; i < 8; i++) set_word(i, 16'h00A0 + 16'(i));
        for (int i = 0; i < 9; i++) push(16'h00A0 + 16'(i % 8), chsel_t'(i % 8), 1'b1);
        apply_stimulus(8'hFF, 1'b1);
        repeat (9) tick();
        apply_stimulus(8'h00, 1'b1);
        tick();
        check_output("rr_sb_empty", 32'(exp_q.size()), 32'h0);
        check_output("rr_drained", 32'(bus.out_valid), 32'h0);

        // Backpressure with b and f valid; pointer now at b.
        set_word(1, 16'hB0B0);
        set_word(5, 16'hF0F0);
        apply_stimulus(8'b0010_0010, 1'b0);
        push(16'hB0B0, 3'd1, 1'b1);
        @(negedge clk);
        check_output("bp_first_ready", 32'(bus.in_ready), 32'h02);
        tick();
        apply_stimulus(8'b0010_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("bp_in_ready", 32'(bus.in_ready), 32'h0);
            check_output("bp_hold_valid", 32'(bus.out_valid), 32'h1);
            check_output("bp_hold_sel", 32'(bus.out_sel), 32'h1);
            check_output("bp_hold_data", 32'(bus.out_data), 32'hB0B0);
            tick();
        end
        apply_stimulus(8'b0010_0000, 1'b1);
        push(16'hF0F0, 3'd5, 1'b1);
        tick();
        apply_stimulus(8'h00, 1'b1);
        tick();
        check_output("bp_sb_empty", 32'(exp_q.size()), 32'h0);

        // Single channel c.
        set_word(2, 16'h1234);
        apply_stimulus(8'b0000_0100, 1'b1);
        push(16'h1234, 3'd2, 1'b1);
        @(negedge clk);
        check_output("single_in_ready", 32'(bus.in_ready), 32'h04);
        tick();
        apply_stimulus(8'h00, 1'b1);
        tick();
        check_output("single_sb_empty", 32'(exp_q.size()), 32'h0);

        // Wrap: grant g, then h before a, then a.
        set_word(6, 16'h6666);
        apply_stimulus(8'b0100_0000, 1'b1);
        push(16'h6666, 3'd6, 1'b1);
        @(negedge clk);
        check_output("wrap_g_ready", 32'(bus.in_ready), 32'h40);
        tick();
        set_word(7, 16'h7777);
        set_word(0, 16'h0A0A);
        apply_stimulus(8'b1000_0001, 1'b1);
        push(16'h7777, 3'd7, 1'b1);
        push(16'h0A0A, 3'd0, 1'b1);
        @(negedge clk);
        check_output("wrap_h_ready", 32'(bus.in_ready), 32'h80);
        tick();
        apply_stimulus(8'b0000_0001, 1'b1);
        @(negedge clk);
        check_output("wrap_a_ready", 32'(bus.in_ready), 32'h01);
        tick();
        apply_stimulus(8'h00, 1'b1);
        tick();
        check_output("wrap_sb_empty", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset while a stalled word is held.
        set_word(4, 16'hEEEE);
        apply_stimulus(8'b0001_0000, 1'b0);
        tick();
        set_word(1, 16'hB1B1);
        apply_stimulus(8'b0001_0010, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_output("arst_out_valid", 32'(bus.out_valid), 32'h0);
        check_output("arst_out_data", 32'(bus.out_data), 32'h0);
        check_output("arst_out_sel", 32'(bus.out_sel), 32'h0);
        check_output("arst_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(8'b0001_0010, 1'b1);
        push(16'hB1B1, 3'd1, 1'b1);
        @(negedge clk);
        check_output("arst_rescan_ready", 32'(bus.in_ready), 32'h02);
        tick();
        apply_stimulus(8'h00, 1'b1);
        tick();
        check_output("arst_sb_empty", 32'(exp_q.size()), 32'h0);

`ifdef MUX8WAY_PKT_LOCK_EN
        // Packet lock: d sends three words while e keeps requesting.
        set_word(4, 16'hE000);
        for (int k = 0; k < 3; k++) begin
            set_word(3, 16'hD000 + 16'(k));
            bus.in_last = (k == 2) ? 8'h18 : 8'h10;
            apply_stimulus(8'h18, 1'b1);
            push(16'hD000 + 16'(k), 3'd3, (k == 2));
            @(negedge clk);
            check_output("lock_d_ready", 32'(bus.in_ready), 32'h08);
            tick();
        end
        bus.in_last = 8'h10;
        apply_stimulus(8'h10, 1'b1);
        push(16'hE000, 3'd4, 1'b1);
        @(negedge clk);
        check_output("lock_e_ready", 32'(bus.in_ready), 32'h10);
        tick();
        apply_stimulus(8'h00, 1'b1);
        tick();
        check_output("lock_sb_empty", 32'(exp_q.size()), 32'h0);
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux8way_rr_collector.md
Name: mux8way_rr_collector

Overview:
- 8-to-1 stream merger: the gathering counterpart to the 8-way demultiplexer that fans one source out by `sel`.
- Collects 16-bit words from eight valid/ready channels a..h with round-robin arbitration.
- Forwards each word through one registered output stage, tagged with its 3-bit source index.
- Sits between per-unit producers and a single shared consumer, e.g. a memory-write port.

Parameters:
- WIDTH, 16, data width of each input channel and of out_data.
- NCH, 8, number of input channels; fixed at 8, since out_sel is 3 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  8  bit i set: channel i (a=0 … h=7) presents a word.
- in_data  input  8*WIDTH  channel i word is in_data[i*WIDTH +: WIDTH].
- in_ready  output  8  one-hot or zero; bit i set: channel i word accepted this cycle.
- out_valid  output  1  out_data/out_sel hold a word.
- out_data  output  WIDTH  forwarded word.
- out_sel  output  3  source channel index of out_data (3'b000=a … 3'b111=h).
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready=0 while reset is high (gated combinationally).
- Load condition: load = !out_valid || out_ready. The output stage can take a new word in the same cycle the old one drains, so throughput is 1 word/clk.
- Arbitration is combinational, on in_valid and rr_ptr:
  - Grant the first channel with in_valid set, scanning rr_ptr, rr_ptr+1, … wrapping mod 8.
  - in_ready = grant one-hot AND load. No grant when in_valid=0, or when load=0.
- Transfer: in_valid[i] && in_ready[i] at the clock edge causes:
  - out_data <= word i, out_sel <= i, out_valid <= 1.
  - rr_ptr <= (i+1) mod 8. Wrap: i=7 gives rr_ptr=0.
- Drain with no refill (out_ready=1, no grant): out_valid <= 0. out_data and out_sel hold their last values.
- Stall (out_valid=1, out_ready=0): out_data, out_sel and rr_ptr are all frozen, and in_ready=0.
- Latency: 1 clk from the accepted input edge to out_valid=1.
- Fairness: a continuously requesting channel waits at most 7 grants.
- Producers must hold in_valid and data stable until in_ready. The block does not check this; withdrawing in_valid before acceptance drops nothing, because nothing is captured.
- No combinational path from out_ready to out_valid. There is a combinational path from out_ready to in_ready.
- Reset mid-transfer: any held output word is discarded, and rr_ptr returns to 0.

Optional Feature:
- Macro: MUX8WAY_PKT_LOCK_EN.
- Defined:
  - Adds port in_last (input, 8), marking the final word of a packet on channel i.
  - After a grant to channel i with in_last[i]=0, the lock holds. During the lock, only channel i can be granted, and rr_ptr does not advance.
  - The lock releases after the transfer whose in_last[i]=1; rr_ptr then becomes i+1.
  - Adds output out_last (1 bit, registered alongside out_data; reset 0).
  - Reset clears the lock.
- Undefined: every word is an independent packet. No in_last/out_last ports exist.

Decomposition:
- Package mux8way_pkg holds:
  - WIDTH_DEFAULT=16 and NCH=8.
  - typedef word_t (logic [15:0]) and typedef chsel_t (logic [2:0]).
  - Function rr_pick(valid[7:0], ptr[2:0]) returning {found, chsel_t}.
- Sub-module rr_arbiter8: combinational rotate-priority-encode, plus the rr_ptr/lock register.
- The top level holds the output register stage and the handshake gating.

Test Plan:
- Reset: assert reset mid-cycle, asynchronously, while out_valid=1 → out_valid, out_data, out_sel and in_ready go to 0 immediately, and the next grant scans from channel a.
- Single channel: in_valid=8'b0000_0100, c=16'h1234, out_ready=1 → in_ready=8'b0000_0100 at the first edge; the next cycle shows out_valid=1, out_data=16'h1234, out_sel=3'b010.
- Round robin:
  - Stimulus: in_valid=8'hFF held with out_ready=1; channel i carries data 16'h00A0+i.
  - Required: out_sel sequence 0,1,2,…,7,0, one per clk, with no bubbles.
  - Required: out_data follows the same sequence, 16'h00A0 through 16'h00A7.
- Backpressure:
  - Stimulus: out_ready=0 for 3 clks with channels b and f valid.
  - Required: the first word (out_sel=1) is held stable and in_ready=0.
  - Required: when out_ready returns to 1, out_sel=5 follows on the next clk.
- Wrap and fairness: rr_ptr=7 (after a grant to g), with in_valid=8'b1000_0001 → h is granted before a, and after h, a is granted (rr_ptr=0).
- MUX8WAY_PKT_LOCK_EN:
  - Stimulus: channel d sends 3 words with in_last on the third, while channel e is continuously valid.
  - Required: out_sel=3,3,3,4, and out_last=1 only on the third word.
